// File: rtl/product_accumulator.sv
// -----------------------------------------------------------------------------
// product_accumulator
//   Sums a programmed number of unsigned products, such as those from the 4x4
//   multiplier, into a wider accumulator. It then holds the result until the
//   downstream side takes it. Both sides use a valid/ready handshake, and the
//   block runs in a single clock domain.
//
//   Ports
//     clk         rising-edge clock
//     rst         synchronous, active-high reset
//     start       begin a new accumulation (honoured in IDLE only)
//     num_terms   number of products to sum, sampled with start
//     prod_valid  product input valid
//     prod_ready  accumulator accepts a product (high in ACCUM)
//     product     unsigned product input
//     acc_out     accumulated sum, meaningful while out_valid is high
//     out_valid   result available
//     out_ready   downstream takes the result
//     overflow    sticky carry out of the accumulator MSB during this run
//     busy        high in ACCUM and DONE
// -----------------------------------------------------------------------------
module product_accumulator #(
  parameter int PROD_WIDTH = 8,
  parameter int ACC_WIDTH  = 16,
  parameter int MAX_TERMS  = 15,
  localparam int NT_W      = $clog2(MAX_TERMS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NT_W-1:0]       num_terms,
  input  logic                  prod_valid,
  output logic                  prod_ready,
  input  logic [PROD_WIDTH-1:0] product,
  output logic [ACC_WIDTH-1:0]  acc_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overflow,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               r_state;
  logic [NT_W-1:0]      r_cnt;
  logic [ACC_WIDTH-1:0] r_acc;
  logic                 r_ovf;
  logic                 r_prod_ready;
  logic                 r_out_valid;
  logic                 r_busy;
  logic [ACC_WIDTH:0]   w_sum;

  // Zero-extends the product and adds it to the accumulator. The extra MSB of
  // the result is the carry that flags wrap-around.
  function automatic logic [ACC_WIDTH:0] acc_add(
    input logic [ACC_WIDTH-1:0]  a,
    input logic [PROD_WIDTH-1:0] p
  );
    logic [ACC_WIDTH:0] ext_a;
    logic [ACC_WIDTH:0] ext_p;
    ext_a                 = {1'b0, a};
    ext_p                 = '0;
    ext_p[PROD_WIDTH-1:0] = p;
    return ext_a + ext_p;
  endfunction

  assign w_sum = acc_add(r_acc, product);

  // The handshake outputs are registered alongside the state. This keeps
  // prod_ready independent of prod_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_acc        <= '0;
      r_ovf        <= 1'b0;
      r_prod_ready <= 1'b0;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc  <= '0;
            r_ovf  <= 1'b0;
            r_cnt  <= num_terms;
            r_busy <= 1'b1;
            if (num_terms == '0) begin
              // With an empty run, go straight to DONE with a zero result.
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_state      <= S_ACCUM;
              r_prod_ready <= 1'b1;
            end
          end
        end

        S_ACCUM: begin
          if (prod_valid) begin
            r_acc <= w_sum[ACC_WIDTH-1:0];
            if (w_sum[ACC_WIDTH]) begin
              r_ovf <= 1'b1;
            end
            r_cnt <= r_cnt - NT_W'(1);
            if (r_cnt == NT_W'(1)) begin
              r_state      <= S_DONE;
              r_prod_ready <= 1'b0;
              r_out_valid  <= 1'b1;
            end
          end
        end

        S_DONE: begin
          // A start that arrives here together with out_ready is dropped on
          // purpose. A new run needs a fresh start pulse in IDLE.
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end

        default: begin
          r_state      <= S_IDLE;
          r_prod_ready <= 1'b0;
          r_out_valid  <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign prod_ready = r_prod_ready;
  assign out_valid  = r_out_valid;
  assign busy       = r_busy;
  assign acc_out    = r_acc;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// -----------------------------------------------------------------------------
// tb_product_accumulator
//   Directed bench for product_accumulator. u_dut uses the default widths, and
//   u_ovf uses a 10-bit accumulator to exercise wrap-around and the overflow
//   flag. Inputs change 1 time unit after the rising edge. Outputs are
//   sampled at the same moment, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst;

  logic        start, prod_valid, out_ready;
  logic [3:0]  num_terms;
  logic [7:0]  product;
  logic        prod_ready, out_valid, overflow, busy;
  logic [15:0] acc_out;

  logic        start2, prod_valid2, out_ready2;
  logic [3:0]  num_terms2;
  logic [7:0]  product2;
  logic        prod_ready2, out_valid2, overflow2, busy2;
  logic [9:0]  acc_out2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  product_accumulator u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_terms  (num_terms),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .product    (product),
    .acc_out    (acc_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overflow   (overflow),
    .busy       (busy)
  );

  product_accumulator #(.PROD_WIDTH(8), .ACC_WIDTH(10), .MAX_TERMS(15)) u_ovf (
    .clk        (clk),
    .rst        (rst),
    .start      (start2),
    .num_terms  (num_terms2),
    .prod_valid (prod_valid2),
    .prod_ready (prod_ready2),
    .product    (product2),
    .acc_out    (acc_out2),
    .out_valid  (out_valid2),
    .out_ready  (out_ready2),
    .overflow   (overflow2),
    .busy       (busy2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; num_terms = '0; prod_valid = 1'b0; product = '0; out_ready = 1'b0;
    start2 = 1'b0; num_terms2 = '0; prod_valid2 = 1'b0; product2 = '0; out_ready2 = 1'b0;

    // Reset
    tick(); tick();
    chk("rst_acc", 32'(acc_out), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_prod_ready", 32'(prod_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_ovf_acc", 32'(acc_out2), 0);
    rst = 1'b0;

    // Basic: 15 + 20 + 14 = 49
    start = 1'b1; num_terms = 4'd3;
    tick();
    start = 1'b0;
    chk("basic_prod_ready", 32'(prod_ready), 1);
    chk("basic_busy", 32'(busy), 1);
    prod_valid = 1'b1; product = 8'd15; tick();
    product = 8'd20; tick();
    chk("basic_not_done_yet", 32'(out_valid), 0);
    product = 8'd14; tick();
    prod_valid = 1'b0;
    chk("basic_out_valid", 32'(out_valid), 1);
    chk("basic_acc", 32'(acc_out), 49);
    chk("basic_overflow", 32'(overflow), 0);
    chk("basic_prod_ready_done", 32'(prod_ready), 0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("basic_retired", 32'(out_valid), 0);
    chk("basic_idle_busy", 32'(busy), 0);
    chk("basic_acc_held_idle", 32'(acc_out), 49);

    // Stalls and backpressure: 100 + 200 = 300
    start = 1'b1; num_terms = 4'd2;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("stall_prod_ready", 32'(prod_ready), 1);
    chk("stall_acc_zero", 32'(acc_out), 0);
    prod_valid = 1'b1; product = 8'd100; tick();
    prod_valid = 1'b0; product = 8'd77;
    tick(); tick(); tick();
    chk("stall_mid_acc", 32'(acc_out), 100);
    chk("stall_mid_valid", 32'(out_valid), 0);
    prod_valid = 1'b1; product = 8'd200; tick();
    prod_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_acc", 32'(acc_out), 300);
      tick();
    end
    // A start pulse that arrives with out_ready in DONE must not begin a run.
    start = 1'b1; out_ready = 1'b1; num_terms = 4'd3;
    tick();
    start = 1'b0; out_ready = 1'b0;
    chk("start_in_done_valid", 32'(out_valid), 0);
    chk("start_in_done_busy", 32'(busy), 0);
    chk("start_in_done_ready", 32'(prod_ready), 0);
    chk("start_in_done_acc", 32'(acc_out), 300);

    // Zero terms
    start = 1'b1; num_terms = 4'd0;
    tick();
    start = 1'b0;
    chk("zero_out_valid", 32'(out_valid), 1);
    chk("zero_acc", 32'(acc_out), 0);
    chk("zero_prod_ready", 32'(prod_ready), 0);
    chk("zero_busy", 32'(busy), 1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("zero_retired", 32'(out_valid), 0);
    chk("zero_ready_after", 32'(prod_ready), 0);

    // Abort with reset after 2 of 4 products
    start = 1'b1; num_terms = 4'd4;
    tick();
    start = 1'b0;
    prod_valid = 1'b1; product = 8'd10; tick();
    product = 8'd20; tick();
    prod_valid = 1'b0;
    chk("abort_pre_acc", 32'(acc_out), 30);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("abort_acc", 32'(acc_out), 0);
    chk("abort_prod_ready", 32'(prod_ready), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_out_valid", 32'(out_valid), 0);

    // A start pulse in ACCUM must leave cnt and acc untouched
    start = 1'b1; num_terms = 4'd2;
    tick();
    start = 1'b0;
    prod_valid = 1'b1; product = 8'd7; tick();
    prod_valid = 1'b0;
    start = 1'b1; num_terms = 4'd5; tick(); start = 1'b0;
    chk("ign_acc", 32'(acc_out), 7);
    chk("ign_prod_ready", 32'(prod_ready), 1);
    chk("ign_out_valid", 32'(out_valid), 0);
    prod_valid = 1'b1; product = 8'd8; tick();
    prod_valid = 1'b0;
    chk("ign_done_valid", 32'(out_valid), 1);
    chk("ign_done_acc", 32'(acc_out), 15);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Overflow on the 10-bit accumulator: 5 x 225 = 1125 -> 101
    start2 = 1'b1; num_terms2 = 4'd5;
    tick();
    start2 = 1'b0;
    prod_valid2 = 1'b1; product2 = 8'd225;
    tick(); tick(); tick(); tick();
    chk("ovf_before_wrap", 32'(overflow2), 0);
    chk("ovf_acc_900", 32'(acc_out2), 900);
    tick();
    prod_valid2 = 1'b0;
    chk("ovf_out_valid", 32'(out_valid2), 1);
    chk("ovf_acc", 32'(acc_out2), 101);
    chk("ovf_flag", 32'(overflow2), 1);
    tick();
    chk("ovf_flag_held", 32'(overflow2), 1);
    out_ready2 = 1'b1; tick(); out_ready2 = 1'b0;
    start2 = 1'b1; num_terms2 = 4'd1;
    tick();
    start2 = 1'b0;
    chk("ovf_cleared_on_start", 32'(overflow2), 0);
    prod_valid2 = 1'b1; product2 = 8'd4; tick();
    prod_valid2 = 1'b0;
    chk("ovf_next_valid", 32'(out_valid2), 1);
    chk("ovf_next_acc", 32'(acc_out2), 4);
    chk("ovf_next_flag", 32'(overflow2), 0);
    out_ready2 = 1'b1; tick(); out_ready2 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
